// File: rtl/block_move_pkg.sv
// Shared types and constants for the moving-block scheduler: command encodings,
// FSM states, default raster geometry and the per-axis bounce step.
package block_move_pkg;

    localparam int DEF_H_DISP     = 1280;
    localparam int DEF_V_DISP     = 720;
    localparam int DEF_BLOCK_SIZE = 40;

    typedef enum logic [1:0] {
        OP_SET_SPEED = 2'd0,
        OP_PAUSE     = 2'd1,
        OP_RESUME    = 2'd2,
        OP_HOME      = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_UPD_X,
        S_UPD_Y,
        S_COMMIT
    } motion_state_e;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    typedef struct packed {
        logic [10:0] pos;
        logic        dir;
    } axis_t;

    // One frame of motion on one axis; hitting either edge clamps and reverses.
    // A zero speed leaves both position and direction untouched.
    function automatic axis_t step_axis(axis_t cur, logic [3:0] spd, logic [10:0] lim);
        axis_t       nxt;
        logic [11:0] sum;
        nxt = cur;
        sum = {1'b0, cur.pos} + {8'b0, spd};
        if (spd != 4'd0) begin
            if (cur.dir == DIR_POS) begin
                if (sum >= {1'b0, lim}) begin
                    nxt.pos = lim;
                    nxt.dir = DIR_NEG;
                end else begin
                    nxt.pos = sum[10:0];
                end
            end else begin
                if (cur.pos <= {7'b0, spd}) begin
                    nxt.pos = '0;
                    nxt.dir = DIR_POS;
                end else begin
                    nxt.pos = cur.pos - {7'b0, spd};
                end
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/block_motion_ctrl_frame_tick_gen.sv
// Registers video_vs once and emits a one-cycle tick on its inactive-to-active edge.
module frame_tick_gen #(
    parameter int VS_POL = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic video_vs,
    output logic frame_tick
);

    logic vs_act;
    logic vs_act_q;

    assign vs_act = (VS_POL != 0) ? video_vs : ~video_vs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_act_q   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vs_act_q   <= vs_act;
            frame_tick <= vs_act & ~vs_act_q;
        end
    end

endmodule

// File: rtl/block_motion_ctrl.sv
// Frame-synchronous moving-block scheduler: applies one pending host command per
// frame, steps the block with edge bounce and commits coordinates during vsync.
module block_motion_ctrl
    import block_move_pkg::*;
#(
    parameter int H_DISP     = DEF_H_DISP,
    parameter int V_DISP     = DEF_V_DISP,
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int VS_POL     = 1
) (
    input  logic        pixel_clk,
    input  logic        sys_rst_n,
    input  logic        video_vs,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_arg,
    output logic [10:0] block_x,
    output logic [10:0] block_y,
    output logic        pos_valid,
    output logic        moving,
    output logic [15:0] frame_cnt
);

    localparam logic [10:0] XMAX = 11'(H_DISP - BLOCK_SIZE);
    localparam logic [10:0] YMAX = 11'(V_DISP - BLOCK_SIZE);

    logic          frame_tick;
    motion_state_e state;
    logic          slot_full;
    cmd_op_e       slot_op;
    logic [7:0]    slot_arg;
    logic [3:0]    spd_x;
    logic [3:0]    spd_y;
    axis_t         ax_x;
    axis_t         ax_y;
    logic          home_skip;
    logic          cmd_fire;

    frame_tick_gen #(
        .VS_POL (VS_POL)
    ) u_tick (
        .clk        (pixel_clk),
        .rst_n      (sys_rst_n),
        .video_vs   (video_vs),
        .frame_tick (frame_tick)
    );

    assign cmd_fire = cmd_valid & cmd_ready;

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
            slot_full <= 1'b0;
            slot_op   <= OP_SET_SPEED;
            slot_arg  <= '0;
            spd_x     <= 4'd1;
            spd_y     <= 4'd1;
            ax_x      <= '{pos: '0, dir: DIR_POS};
            ax_y      <= '{pos: '0, dir: DIR_POS};
            home_skip <= 1'b0;
            moving    <= 1'b1;
            block_x   <= '0;
            block_y   <= '0;
            pos_valid <= 1'b0;
            frame_cnt <= '0;
        end else begin
            pos_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        slot_full <= 1'b1;
                        slot_op   <= cmd_op_e'(cmd_op);
                        slot_arg  <= cmd_arg;
                    end
                    // A command arriving with the tick still lands in this frame's APPLY.
                    if (frame_tick) begin
                        state     <= S_APPLY;
                        cmd_ready <= 1'b0;
                    end else begin
                        cmd_ready <= ~(slot_full | cmd_fire);
                    end
                end
                S_APPLY: begin
                    slot_full <= 1'b0;
                    home_skip <= 1'b0;
                    if (slot_full) begin
                        case (slot_op)
                            OP_SET_SPEED: begin
                                spd_x <= slot_arg[3:0];
                                spd_y <= slot_arg[7:4];
                            end
                            OP_PAUSE:  moving <= 1'b0;
                            OP_RESUME: moving <= 1'b1;
                            OP_HOME: begin
                                ax_x      <= '{pos: '0, dir: DIR_POS};
                                ax_y      <= '{pos: '0, dir: DIR_POS};
                                home_skip <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    state <= S_UPD_X;
                end
                S_UPD_X: begin
                    if (moving && !home_skip) begin
                        ax_x <= step_axis(ax_x, spd_x, XMAX);
                    end
                    state <= S_UPD_Y;
                end
                S_UPD_Y: begin
                    if (moving && !home_skip) begin
                        ax_y <= step_axis(ax_y, spd_y, YMAX);
                    end
                    state <= S_COMMIT;
                end
                S_COMMIT: begin
                    block_x   <= ax_x.pos;
                    block_y   <= ax_y.pos;
                    pos_valid <= 1'b1;
                    frame_cnt <= frame_cnt + 16'd1;
                    cmd_ready <= ~slot_full;
                    state     <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_motion_ctrl.sv
// Directed bench for block_motion_ctrl with hand-computed positions per frame.
module tb_block_motion_ctrl;

    logic        pixel_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        video_vs  = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op    = '0;
    logic [7:0]  cmd_arg   = '0;
    logic        cmd_ready;
    logic [10:0] block_x;
    logic [10:0] block_y;
    logic        pos_valid;
    logic        moving;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int lat;

    block_motion_ctrl #(
        .H_DISP     (1280),
        .V_DISP     (720),
        .BLOCK_SIZE (40),
        .VS_POL     (1)
    ) dut (
        .pixel_clk (pixel_clk),
        .sys_rst_n (sys_rst_n),
        .video_vs  (video_vs),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .block_x   (block_x),
        .block_y   (block_y),
        .pos_valid (pos_valid),
        .moving    (moving),
        .frame_cnt (frame_cnt)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Raises vsync, waits (bounded) for the commit pulse, checks it lasts one cycle.
    // With glitch set, vsync drops and re-rises while the FSM is busy.
    task automatic run_frame(input bit glitch, output int latency);
        latency = 0;
        @(negedge pixel_clk) video_vs = 1'b1;
        do begin
            @(negedge pixel_clk);
            latency++;
            if (glitch && latency == 1) video_vs = 1'b0;
            if (glitch && latency == 2) video_vs = 1'b1;
        end while (!pos_valid && latency < 20);
        if (!pos_valid) check_val("pos_valid_timeout", 32'd0, 32'd1);
        @(negedge pixel_clk);
        check_val("pos_valid_width", 32'(pos_valid), 32'd0);
        video_vs = 1'b0;
        repeat (3) @(negedge pixel_clk);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge pixel_clk);
            n++;
        end
        if (!cmd_ready) check_val("cmd_ready_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge pixel_clk);
        cmd_valid = 1'b0;
        check_val("cmd_ready_after_accept", 32'(cmd_ready), 32'd0);
    endtask

    task automatic check_pos(input string tag, input int x, input int y);
        check_val({tag, "_x"}, 32'(block_x), 32'(x));
        check_val({tag, "_y"}, 32'(block_y), 32'(y));
    endtask

    initial begin
        repeat (3) @(negedge pixel_clk);
        check_pos("rst", 0, 0);
        check_val("rst_pos_valid", 32'(pos_valid), 32'd0);
        check_val("rst_moving", 32'(moving), 32'd1);
        check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        sys_rst_n = 1'b1;
        @(negedge pixel_clk);
        check_val("ready_after_rst", 32'(cmd_ready), 32'd1);

        run_frame(1'b0, lat);
        check_val("latency", 32'(lat), 32'd6);
        check_pos("f1", 1, 1);
        run_frame(1'b0, lat);
        check_pos("f2", 2, 2);
        run_frame(1'b0, lat);
        check_pos("f3", 3, 3);
        check_val("f3_frame_cnt", 32'(frame_cnt), 32'd3);

        // x speed 15, y speed 0: 3 + 15*81 = 1218, y stays 3
        send_cmd(2'd0, 8'h0F);
        for (int i = 0; i < 81; i++) run_frame(1'b0, lat);
        check_pos("fast", 1218, 3);
        send_cmd(2'd0, 8'h0C);
        run_frame(1'b0, lat);
        check_pos("near_edge", 1230, 3);
        send_cmd(2'd0, 8'h5A);
        run_frame(1'b0, lat);
        check_pos("bounce_right", 1240, 8);
        run_frame(1'b0, lat);
        check_pos("after_bounce", 1230, 13);
        check_val("bounce_frame_cnt", 32'(frame_cnt), 32'd87);

        send_cmd(2'd1, 8'h00);
        run_frame(1'b0, lat);
        run_frame(1'b0, lat);
        check_pos("paused", 1230, 13);
        check_val("paused_moving", 32'(moving), 32'd0);
        check_val("paused_frame_cnt", 32'(frame_cnt), 32'd89);
        send_cmd(2'd2, 8'h00);
        run_frame(1'b0, lat);
        check_pos("resumed", 1220, 18);
        check_val("resumed_moving", 32'(moving), 32'd1);

        run_frame(1'b1, lat);
        check_pos("glitch", 1210, 23);
        check_val("glitch_frame_cnt", 32'(frame_cnt), 32'd91);

        send_cmd(2'd3, 8'h00);
        run_frame(1'b0, lat);
        check_pos("home", 0, 0);
        run_frame(1'b0, lat);
        check_pos("after_home", 10, 5);

        // second command waits in cmd_valid until the slot is drained by APPLY
        send_cmd(2'd0, 8'h21);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_arg   = 8'h43;
        repeat (2) @(negedge pixel_clk);
        check_val("slot_full_ready", 32'(cmd_ready), 32'd0);
        run_frame(1'b0, lat);
        cmd_valid = 1'b0;
        check_pos("first_cmd", 11, 7);
        check_val("second_pending_ready", 32'(cmd_ready), 32'd0);
        run_frame(1'b0, lat);
        check_pos("second_cmd", 14, 11);
        check_val("slot_frame_cnt", 32'(frame_cnt), 32'd95);

        // reset while the FSM sits in UPD_X
        @(negedge pixel_clk) video_vs = 1'b1;
        repeat (3) @(negedge pixel_clk);
        sys_rst_n = 1'b0;
        #1;
        check_pos("mid_rst", 0, 0);
        check_val("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_val("mid_rst_moving", 32'(moving), 32'd1);
        check_val("mid_rst_pos_valid", 32'(pos_valid), 32'd0);
        check_val("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        video_vs = 1'b0;
        repeat (2) @(negedge pixel_clk);
        sys_rst_n = 1'b1;
        @(negedge pixel_clk);
        run_frame(1'b0, lat);
        check_pos("post_rst", 1, 1);
        check_val("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_motion_ctrl.md
# block_motion_ctrl

Frame-synchronous scheduler for the moving-block HDMI pattern: once per video frame it applies any pending host command, advances the block position with edge bounce, and commits new coordinates during vertical sync so the pixel generator never tears mid-frame. It sits in the pixel_clk domain between the video timing driver (source of video_vs) and the display pattern logic, which consumes block_x/block_y.

## Interface
- H_DISP, 1280: active pixels per line
- V_DISP, 720: active lines per frame
- BLOCK_SIZE, 40: block edge length in pixels
- VS_POL, 1: active level of video_vs (1 = high-active)

- pixel_clk  in  1  pixel clock; sole clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- video_vs  in  1  vertical sync from the timing driver, pixel_clk domain
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  0 SET_SPEED, 1 PAUSE, 2 RESUME, 3 HOME
- cmd_arg  in  8  SET_SPEED: [3:0] x speed, [7:4] y speed (pixels/frame); ignored otherwise
- block_x  out  11  top-left x of block, 0..H_DISP-BLOCK_SIZE
- block_y  out  11  top-left y of block, 0..V_DISP-BLOCK_SIZE
- pos_valid  out  1  one-cycle pulse when new coordinates commit
- moving  out  1  1 = motion enabled
- frame_cnt  out  16  frames seen, wraps

## Operation
- Frame tick: one-cycle pulse on the inactive-to-active transition of video_vs (per VS_POL), from one registered sample.
- FSM: IDLE -> APPLY -> UPD_X -> UPD_Y -> COMMIT -> IDLE. Leave IDLE only on frame tick; each other state lasts one cycle.
- Command slot: single pending register. cmd_ready = 1 in IDLE with slot empty, else 0. On handshake op/arg are latched and slot marked full. Cleared in APPLY.
- APPLY: SET_SPEED loads spd_x/spd_y; PAUSE clears moving; RESUME sets moving; HOME forces x=y=0, dir_x=dir_y=+ and skips motion this frame.
- UPD_X (only if moving and not HOME): XMAX = H_DISP-BLOCK_SIZE. Dir +: if x+spd_x >= XMAX then x=XMAX, dir=-; else x+=spd_x. Dir -: if x <= spd_x then x=0, dir=+; else x-=spd_x. Sum in 12 bits, no overflow. spd=0 leaves x and dir unchanged.
- UPD_Y: same rule with YMAX = V_DISP-BLOCK_SIZE.
- COMMIT: working x/y copied to block_x/block_y, pos_valid=1, frame_cnt+=1.
- Frame tick outside IDLE: ignored, not counted.
- cmd_valid during same cycle as frame tick in IDLE: command accepted and applied in that frame's APPLY.

## Timing
- Reset values: block_x=0, block_y=0, pos_valid=0, moving=1, frame_cnt=0, cmd_ready=0; internal spd_x=spd_y=1, dir +,+, slot empty, state IDLE. cmd_ready rises on the first clock after reset release.
- Latency: video_vs active edge sampled at cycle N -> tick N+1 -> new block_x/block_y and pos_valid at N+5.
- block_x/block_y change only in COMMIT; stable for the rest of the frame.
- Reset asserted mid-sequence: all state returns to reset values immediately; pending command discarded.

## Structure
- Shared package block_move_pkg: cmd_op encodings, FSM state enum, default H_DISP/V_DISP/BLOCK_SIZE constants.
- One sub-module: frame_tick_gen (video_vs register + edge detect, VS_POL-parametrised).

## Test plan
- Reset release, 3 frames, defaults -> block (1,1),(2,2),(3,3); pos_valid pulses 3 times; frame_cnt=3.
- SET_SPEED arg=0x5A at x=1230, dir + -> next frame x=1240 (XMAX), dir -; following frame x=1230.
- PAUSE, 2 frames -> block_x/y unchanged, frame_cnt +2, moving=0; RESUME -> motion resumes next frame.
- HOME at (500,300) dir -,- -> next commit (0,0); following frame (spd_x, spd_y), dir +,+.
- Command issued while slot full (second cmd_valid before frame) -> cmd_ready=0, second command held until after APPLY, applied one frame later.
- sys_rst_n pulsed low during UPD_X -> all outputs at reset values in same cycle; next frame yields (1,1).
